// File: rtl/axi_read_arbiter.sv
// Two-master to one-slave AXI read arbiter: one outstanding burst at a time,
// round-robin between masters when both request together, R beats routed by the registered grant.
module axi_read_arbiter #(
   parameter int unsigned IDW   = 4,
   parameter int unsigned ADDRW = 32,
   parameter int unsigned DATAW = 32,
   parameter int unsigned LENW  = 4
) (
   input  logic                 ACLK,
   input  logic                 ARESETn,

   input  logic [2*IDW-1:0]     M_ARID,
   input  logic [2*ADDRW-1:0]   M_ARADDR,
   input  logic [2*LENW-1:0]    M_ARLEN,
   input  logic [1:0]           M_ARVALID,
   output logic [1:0]           M_ARREADY,
   output logic [IDW-1:0]       M_RID,
   output logic [DATAW-1:0]     M_RDATA,
   output logic [1:0]           M_RRESP,
   output logic                 M_RLAST,
   output logic [1:0]           M_RVALID,
   input  logic [1:0]           M_RREADY,

   output logic [IDW:0]         S_ARID,
   output logic [ADDRW-1:0]     S_ARADDR,
   output logic [LENW-1:0]      S_ARLEN,
   output logic                 S_ARVALID,
   input  logic                 S_ARREADY,
   input  logic [IDW:0]         S_RID,
   input  logic [DATAW-1:0]     S_RDATA,
   input  logic [1:0]           S_RRESP,
   input  logic                 S_RLAST,
   input  logic                 S_RVALID,
   output logic                 S_RREADY
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t state;
   logic   g;
   logic   p;

   logic             in_addr;
   logic             in_data;
   logic             grant_next;
   logic             sel_arvalid;
   logic [IDW-1:0]   sel_arid;
   logic [ADDRW-1:0] sel_araddr;
   logic [LENW-1:0]  sel_arlen;
   logic             ar_hs;
   logic             r_done;

   // The slave's ID MSB echoes the grant, but routing trusts the registered grant alone.
   logic unused_rid_msb;
   assign unused_rid_msb = S_RID[IDW];

   // Gating with ARESETn keeps every output low while reset is held, even before the first edge.
   assign in_addr = ARESETn && (state == ADDR);
   assign in_data = ARESETn && (state == DATA);

   assign grant_next  = (M_ARVALID == 2'b11) ? p : M_ARVALID[1];

   assign sel_arvalid = M_ARVALID[g];
   assign sel_arid    = g ? M_ARID[2*IDW-1:IDW]       : M_ARID[IDW-1:0];
   assign sel_araddr  = g ? M_ARADDR[2*ADDRW-1:ADDRW] : M_ARADDR[ADDRW-1:0];
   assign sel_arlen   = g ? M_ARLEN[2*LENW-1:LENW]    : M_ARLEN[LENW-1:0];

   assign ar_hs  = in_addr && sel_arvalid && S_ARREADY;
   assign r_done = in_data && S_RVALID && M_RREADY[g] && S_RLAST;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state <= IDLE;
         g     <= 1'b0;
         p     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|M_ARVALID) begin
                  g     <= grant_next;
                  state <= ADDR;
               end
            end
            ADDR: begin
               if (ar_hs) state <= DATA;
            end
            DATA: begin
               if (r_done) begin
                  p     <= ~g;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default first so no path through this block infers a latch.
   always_comb begin
      S_ARVALID = 1'b0;
      S_ARID    = '0;
      S_ARADDR  = '0;
      S_ARLEN   = '0;
      M_ARREADY = 2'b00;
      M_RVALID  = 2'b00;
      S_RREADY  = 1'b0;
      M_RID     = '0;
      M_RDATA   = '0;
      M_RRESP   = 2'b00;
      M_RLAST   = 1'b0;

      if (in_addr) begin
         S_ARVALID    = sel_arvalid;
         S_ARID       = {g, sel_arid};
         S_ARADDR     = sel_araddr;
         S_ARLEN      = sel_arlen;
         M_ARREADY[g] = S_ARREADY;
      end

      if (in_data) begin
         M_RVALID[g] = S_RVALID;
         S_RREADY    = M_RREADY[g];
         M_RID       = S_RID[IDW-1:0];
         M_RDATA     = S_RDATA;
         M_RRESP     = S_RRESP;
         M_RLAST     = S_RLAST;
      end
   end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: expected AR/R transfers are queued as stimulus is
// issued, and a negedge monitor pops and compares each handshake the DUT presents.
module tb_axi_read_arbiter;

   localparam int IDW   = 4;
   localparam int ADDRW = 32;
   localparam int DATAW = 32;
   localparam int LENW  = 4;

   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;

   logic [2*IDW-1:0]   M_ARID;
   logic [2*ADDRW-1:0] M_ARADDR;
   logic [2*LENW-1:0]  M_ARLEN;
   logic [1:0]         M_ARVALID;
   logic [1:0]         M_ARREADY;
   logic [IDW-1:0]     M_RID;
   logic [DATAW-1:0]   M_RDATA;
   logic [1:0]         M_RRESP;
   logic               M_RLAST;
   logic [1:0]         M_RVALID;
   logic [1:0]         M_RREADY;
   logic [IDW:0]       S_ARID;
   logic [ADDRW-1:0]   S_ARADDR;
   logic [LENW-1:0]    S_ARLEN;
   logic               S_ARVALID;
   logic               S_ARREADY;
   logic [IDW:0]       S_RID;
   logic [DATAW-1:0]   S_RDATA;
   logic [1:0]         S_RRESP;
   logic               S_RLAST;
   logic               S_RVALID;
   logic               S_RREADY;

   // master-side drivers (owned by the main process)
   logic m0v, m1v;
   logic [IDW-1:0]   m0_id, m1_id;
   logic [ADDRW-1:0] m0_addr, m1_addr;
   logic [LENW-1:0]  m0_len, m1_len;
   logic rr0, rr1;
   logic tog1 = 1'b0;
   int   stall_knob = 0;

   assign M_ARVALID = {m1v, m0v};
   assign M_ARID    = {m1_id, m0_id};
   assign M_ARADDR  = {m1_addr, m0_addr};
   assign M_ARLEN   = {m1_len, m0_len};
   assign M_RREADY  = {rr1, rr0};

   axi_read_arbiter #(.IDW(IDW), .ADDRW(ADDRW), .DATAW(DATAW), .LENW(LENW)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARVALID(M_ARVALID),
      .M_ARREADY(M_ARREADY), .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
      .M_RLAST(M_RLAST), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
      .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARVALID(S_ARVALID),
      .S_ARREADY(S_ARREADY), .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
      .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
   );

   always #5 ACLK = ~ACLK;

   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   typedef struct {
      logic [IDW:0]     arid;
      logic [ADDRW-1:0] addr;
      logic [LENW-1:0]  len;
   } ar_t;

   typedef struct {
      logic [1:0]       mvalid;
      logic [IDW-1:0]   rid;
      logic [DATAW-1:0] data;
      logic [1:0]       resp;
      logic             last;
   } r_t;

   ar_t exp_ar[$];
   r_t  exp_r[$];

   int n_checks = 0;
   int n_errors = 0;
   int r_beats = 0;
   int start_cyc = 0;
   int ar_rise_cyc = -100;

   task automatic check(input bit ok, input string name, input string detail);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   // Slave model returns data = addr + beat, resp = beat[1:0], and echoes the AR ID.
   task automatic push_burst(input bit m, input logic [IDW-1:0] id, input logic [ADDRW-1:0] addr,
                             input logic [LENW-1:0] len, input int nbeats);
      ar_t a;
      r_t  r;
      a.arid = {m, id};
      a.addr = addr;
      a.len  = len;
      exp_ar.push_back(a);
      for (int b = 0; b < nbeats; b++) begin
         r.mvalid = m ? 2'b10 : 2'b01;
         r.rid    = id;
         r.data   = addr + 32'(b);
         r.resp   = b[1:0];
         r.last   = (b == int'(len));
         exp_r.push_back(r);
      end
   endtask

   // Slave: one burst at a time, optional AR stall, idle R fields deliberately non-zero.
   initial begin : slave
      logic busy;
      logic [LENW-1:0]  beat, len;
      logic [IDW:0]     id, c_id;
      logic [ADDRW-1:0] addr, c_addr;
      logic [LENW-1:0]  c_len;
      bit s_rst, s_arhs, s_rhs, s_stall;
      int stalled;
      busy = 1'b0; beat = '0; len = '0; id = '0; addr = '0; stalled = 0;
      S_ARREADY = 1'b1; S_RVALID = 1'b0; S_RID = '1; S_RDATA = 32'hDEAD_BEEF;
      S_RRESP = 2'b11; S_RLAST = 1'b1;
      forever begin
         @(negedge ACLK);
         s_rst   = !ARESETn;
         s_arhs  = S_ARVALID && S_ARREADY;
         s_rhs   = S_RVALID && S_RREADY;
         s_stall = S_ARVALID && !S_ARREADY;
         c_id = S_ARID; c_addr = S_ARADDR; c_len = S_ARLEN;
         @(posedge ACLK); #1;
         if (s_rst) begin
            busy = 1'b0;
            stalled = 0;
         end else begin
            if (s_rhs) begin
               if (beat == len) busy = 1'b0;
               else beat = beat + 1'b1;
            end
            if (s_arhs) begin
               busy = 1'b1; beat = '0; id = c_id; addr = c_addr; len = c_len; stalled = 0;
            end
            if (s_stall) stalled++;
         end
         S_ARREADY = !busy && (stalled >= stall_knob);
         if (busy) begin
            S_RVALID = 1'b1; S_RID = id; S_RDATA = addr + 32'(beat);
            S_RRESP = beat[1:0]; S_RLAST = (beat == len);
         end else begin
            S_RVALID = 1'b0; S_RID = '1; S_RDATA = 32'hDEAD_BEEF;
            S_RRESP = 2'b11; S_RLAST = 1'b1;
         end
      end
   end

   initial begin : rready_drv
      rr0 = 1'b1;
      rr1 = 1'b1;
      forever begin
         @(posedge ACLK); #1;
         rr1 = tog1 ? ~rr1 : 1'b1;
      end
   end

   initial begin : monitor
      ar_t ea;
      r_t  er;
      logic prev_sarv;
      prev_sarv = 1'b0;
      forever begin
         @(negedge ACLK);
         if (ARESETn) begin
            if (S_ARVALID && !prev_sarv) ar_rise_cyc = cyc;
            if (M_RVALID != 2'b00 || M_ARREADY != 2'b00)
               check($onehot0(M_RVALID) && $onehot0(M_ARREADY), "onehot_routing",
                      $sformatf("got rvalid=%b arready=%b", M_RVALID, M_ARREADY));
            if (S_ARVALID && !S_ARREADY)
               check(M_ARREADY == 2'b00, "arready_during_stall",
                     $sformatf("got M_ARREADY=%b want 00", M_ARREADY));
            if (S_ARVALID && S_ARREADY) begin
               if (exp_ar.size() == 0) begin
                  check(1'b0, "ar_unexpected", $sformatf("got id=%h addr=%h", S_ARID, S_ARADDR));
               end else begin
                  ea = exp_ar.pop_front();
                  check(S_ARID == ea.arid && S_ARADDR == ea.addr && S_ARLEN == ea.len, "ar_fields",
                        $sformatf("got id=%h addr=%h len=%h want id=%h addr=%h len=%h",
                                  S_ARID, S_ARADDR, S_ARLEN, ea.arid, ea.addr, ea.len));
                  check(M_ARREADY == (ea.arid[IDW] ? 2'b10 : 2'b01), "ar_grant_ready",
                        $sformatf("got M_ARREADY=%b for master %0d", M_ARREADY, ea.arid[IDW]));
               end
            end
            if ((M_RVALID & M_RREADY) != 2'b00) begin
               r_beats++;
               if (exp_r.size() == 0) begin
                  check(1'b0, "r_unexpected", $sformatf("got rvalid=%b data=%h", M_RVALID, M_RDATA));
               end else begin
                  er = exp_r.pop_front();
                  check(M_RVALID == er.mvalid && M_RID == er.rid && M_RDATA == er.data &&
                        M_RRESP == er.resp && M_RLAST == er.last, "r_beat",
                        $sformatf("got v=%b id=%h d=%h resp=%b last=%b want v=%b id=%h d=%h resp=%b last=%b",
                                  M_RVALID, M_RID, M_RDATA, M_RRESP, M_RLAST,
                                  er.mvalid, er.rid, er.data, er.resp, er.last));
               end
            end
         end
         prev_sarv = ARESETn && S_ARVALID;
      end
   end

   // Master m issues n_m requests back to back: addr = a_m + k*0x100, id = i_m + k.
   task automatic run_masters(input int n0, input int n1,
                              input logic [ADDRW-1:0] a0, input logic [ADDRW-1:0] a1,
                              input logic [IDW-1:0] i0, input logic [IDW-1:0] i1,
                              input logic [LENW-1:0] l0, input logic [LENW-1:0] l1,
                              input int d0);
      int k0 = 0;
      int k1 = 0;
      int c = 0;
      bit hs0, hs1;
      m0_addr = a0; m0_id = i0; m0_len = l0;
      m1_addr = a1; m1_id = i1; m1_len = l1;
      m1v = (n1 > 0);
      m0v = (n0 > 0) && (d0 == 0);
      start_cyc = cyc;
      while ((k0 < n0 || k1 < n1) && c < 3000) begin
         @(negedge ACLK);
         hs0 = m0v && M_ARREADY[0];
         hs1 = m1v && M_ARREADY[1];
         @(posedge ACLK); #1;
         c++;
         if (hs0) begin
            k0++;
            if (k0 < n0) begin m0_addr = a0 + 32'(k0) * 32'h100; m0_id = i0 + IDW'(k0); end
            else m0v = 1'b0;
         end
         if (hs1) begin
            k1++;
            if (k1 < n1) begin m1_addr = a1 + 32'(k1) * 32'h100; m1_id = i1 + IDW'(k1); end
            else m1v = 1'b0;
         end
         if (d0 > 0 && c == d0 && n0 > 0) m0v = 1'b1;
      end
      check(k0 == n0 && k1 == n1, "ar_complete",
            $sformatf("got %0d/%0d accepted want %0d/%0d", k0, k1, n0, n1));
   endtask

   task automatic drain();
      int c = 0;
      while ((exp_ar.size() != 0 || exp_r.size() != 0) && c < 500) begin
         @(posedge ACLK); #1;
         c++;
      end
      check(exp_ar.size() == 0 && exp_r.size() == 0, "drain",
            $sformatf("got %0d AR and %0d R still pending want 0", exp_ar.size(), exp_r.size()));
   endtask

   task automatic outputs_zero(input string name);
      @(negedge ACLK);
      check(S_ARVALID == 0 && S_RREADY == 0 && M_ARREADY == 0 && M_RVALID == 0 &&
            M_RID == 0 && M_RDATA == 0 && M_RRESP == 0 && M_RLAST == 0 &&
            S_ARID == 0 && S_ARADDR == 0 && S_ARLEN == 0, name,
            $sformatf("got arv=%b rrdy=%b arrdy=%b rv=%b rid=%h rdata=%h rresp=%b rlast=%b want all 0",
                      S_ARVALID, S_RREADY, M_ARREADY, M_RVALID, M_RID, M_RDATA, M_RRESP, M_RLAST));
   endtask

   task automatic do_reset(input int n);
      @(posedge ACLK); #1;
      ARESETn = 1'b0;
      repeat (n) begin @(posedge ACLK); #1; end
      ARESETn = 1'b1;
   endtask

   initial begin : main
      int target;
      m0v = 1'b1; m1v = 1'b0;
      m0_id = 4'h3; m0_addr = 32'h0000_0F00; m0_len = 4'h2;
      m1_id = '0;   m1_addr = '0;            m1_len = '0;

      // reset held with a master requesting: everything stays low
      repeat (2) @(posedge ACLK);
      #1;
      outputs_zero("reset_outputs");
      @(posedge ACLK); #1;
      m0v = 1'b0;
      ARESETn = 1'b1;
      outputs_zero("post_reset_idle");

      // single M0 request, len 0
      push_burst(1'b0, 4'h5, 32'h0000_1000, 4'h0, 1);
      @(posedge ACLK); #1;
      run_masters(1, 0, 32'h0000_1000, 32'h0, 4'h5, 4'h0, 4'h0, 4'h0, 0);
      drain();
      check(ar_rise_cyc - start_cyc == 1, "ar_latency",
            $sformatf("got %0d cycles want 1", ar_rise_cyc - start_cyc));
      outputs_zero("idle_after_single");

      // both request together right after reset: M0 then M1
      do_reset(2);
      push_burst(1'b0, 4'h2, 32'h0000_3000, 4'h1, 2);
      push_burst(1'b1, 4'h9, 32'h0000_4000, 4'h0, 1);
      run_masters(1, 1, 32'h0000_3000, 32'h0000_4000, 4'h2, 4'h9, 4'h1, 4'h0, 0);
      drain();

      // M1 len 3 with its RREADY toggling
      tog1 = 1'b1;
      push_burst(1'b1, 4'hA, 32'h0000_5000, 4'h3, 4);
      @(posedge ACLK); #1;
      run_masters(0, 1, 32'h0, 32'h0000_5000, 4'h0, 4'hA, 4'h0, 4'h3, 0);
      drain();
      tog1 = 1'b0;
      outputs_zero("idle_after_throttled");

      // AR stalled 5 cycles while M1 holds the grant and M0 arrives
      stall_knob = 5;
      push_burst(1'b1, 4'h3, 32'h0000_6000, 4'h0, 1);
      push_burst(1'b0, 4'h4, 32'h0000_7000, 4'h1, 2);
      @(posedge ACLK); #1;
      run_masters(1, 1, 32'h0000_7000, 32'h0000_6000, 4'h4, 4'h3, 4'h1, 4'h0, 2);
      drain();
      stall_knob = 0;

      // reset during the second beat of a 4-beat M0 burst
      push_burst(1'b0, 4'h6, 32'h0000_8000, 4'h3, 1);
      target = r_beats + 1;
      @(posedge ACLK); #1;
      run_masters(1, 0, 32'h0000_8000, 32'h0, 4'h6, 4'h0, 4'h3, 4'h0, 0);
      for (int c = 0; c < 50 && r_beats < target; c++) begin
         @(posedge ACLK); #1;
      end
      check(r_beats == target, "first_beat_before_reset",
            $sformatf("got %0d beats want %0d", r_beats, target));
      ARESETn = 1'b0;
      outputs_zero("outputs_in_mid_data_reset");
      @(posedge ACLK); #1;
      ARESETn = 1'b1;
      outputs_zero("idle_after_mid_data_reset");
      check(exp_r.size() == 0, "no_beats_left", $sformatf("got %0d pending want 0", exp_r.size()));

      // pointer back to 0: M0 wins over M1
      push_burst(1'b0, 4'h1, 32'h0000_9000, 4'h0, 1);
      push_burst(1'b1, 4'h2, 32'h0000_A000, 4'h0, 1);
      @(posedge ACLK); #1;
      run_masters(1, 1, 32'h0000_9000, 32'h0000_A000, 4'h1, 4'h2, 4'h0, 4'h0, 0);
      drain();

      // 8 continuous bursts: grants alternate M0, M1, M0, ...
      for (int k = 0; k < 4; k++) begin
         push_burst(1'b0, IDW'(k),     32'h0000_B000 + 32'(k) * 32'h100, 4'h1, 2);
         push_burst(1'b1, IDW'(8 + k), 32'h0000_C000 + 32'(k) * 32'h100, 4'h2, 3);
      end
      @(posedge ACLK); #1;
      run_masters(4, 4, 32'h0000_B000, 32'h0000_C000, 4'h0, 4'h8, 4'h1, 4'h2, 0);
      drain();
      outputs_zero("idle_at_end");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 SHALL have parameter IDW, default 4, master-side AXI ID width.
REQ-002 SHALL have parameter ADDRW, default 32, address width.
REQ-003 SHALL have parameter DATAW, default 32, read data width.
REQ-004 SHALL have parameter LENW, default 4, burst length width.
REQ-005 SHALL have port ACLK  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port ARESETn  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port M_ARID  in  2*IDW  per-master AR ID, master i at slice i.
REQ-008 SHALL have port M_ARADDR  in  2*ADDRW  per-master AR address.
REQ-009 SHALL have port M_ARLEN  in  2*LENW  per-master burst length (beats-1).
REQ-010 SHALL have port M_ARVALID  in  2  per-master AR valid.
REQ-011 SHALL have port M_ARREADY  out  2  per-master AR ready.
REQ-012 SHALL have port M_RID  out  IDW  R ID, shared by both masters.
REQ-013 SHALL have port M_RDATA  out  DATAW  R data, shared.
REQ-014 SHALL have port M_RRESP  out  2  R response, shared.
REQ-015 SHALL have port M_RLAST  out  1  R last, shared.
REQ-016 SHALL have port M_RVALID  out  2  per-master R valid.
REQ-017 SHALL have port M_RREADY  in  2  per-master R ready.
REQ-018 SHALL have port S_ARID  out  IDW+1  slave-side AR ID, MSB = granted master.
REQ-019 SHALL have ports S_ARADDR out ADDRW, S_ARLEN out LENW, S_ARVALID out 1, S_ARREADY in 1  slave-side AR channel.
REQ-020 SHALL have ports S_RID in IDW+1, S_RDATA in DATAW, S_RRESP in 2, S_RLAST in 1, S_RVALID in 1, S_RREADY out 1  slave-side R channel.

Function
REQ-021 SHALL implement FSM states IDLE, ADDR, DATA plus registered grant index g (1 bit) and round-robin pointer p (1 bit).
REQ-022 IDLE: if any M_ARVALID set, SHALL register g (single requester wins; both requesting -> g=p) and go to ADDR next cycle; else stay.
REQ-023 ADDR: S_ARVALID = M_ARVALID[g]; S_ARADDR/S_ARLEN = slice g; S_ARID = {g, M_ARID slice g}; M_ARREADY[g] = S_ARREADY; other M_ARREADY bit = 0.
REQ-024 ADDR -> DATA on S_ARVALID & S_ARREADY; otherwise stay in ADDR (no timeout).
REQ-025 DATA: M_RVALID[g] = S_RVALID; S_RREADY = M_RREADY[g]; M_RID = S_RID[IDW-1:0]; M_RDATA/M_RRESP/M_RLAST pass S_R* combinationally.
REQ-026 DATA -> IDLE on S_RVALID & S_RREADY & S_RLAST; same edge p <= ~g.
REQ-027 Outside ADDR: S_ARVALID = 0, M_ARREADY = 0; outside DATA: M_RVALID = 0, S_RREADY = 0.
REQ-028 R routing SHALL use g only; S_RID MSB is not used for routing.
REQ-029 Latency: S_ARVALID earliest 1 cycle after M_ARVALID rises in IDLE; R path zero-cycle combinational.
REQ-030 Only one outstanding burst; a new grant SHALL NOT occur before the RLAST handshake of the current burst.
REQ-031 Non-granted master SHALL see ARREADY=0 and RVALID=0 for the whole transaction.
REQ-032 Pointer SHALL only change at burst completion, never on single-requester grant without completion.
REQ-033 Bursts of any length 1..2^LENW SHALL be passed; beats not counted, completion by S_RLAST only.

Reset
REQ-034 ARESETn low at any edge SHALL force state IDLE, g=0, p=0 (M0 favoured) next cycle, including mid-ADDR or mid-DATA.
REQ-035 During and after reset all outputs SHALL be 0 (S_ARVALID, S_RREADY, M_ARREADY, M_RVALID; data pass-throughs 0 when not in DATA).

Verification
REQ-036 Reset, M0 ARVALID addr 0x1000 len 0 only -> S_ARVALID cycle+1, S_ARID={0,M0 id}, one beat routed M_RVALID=2'b01, back to IDLE.
REQ-037 Both ARVALID same cycle after reset -> M0 served first, p=1, M1 served next with S_ARID MSB=1.
REQ-038 M1 burst len 3 with S_RREADY throttled by M_RREADY[1] toggling -> exactly 4 beats delivered, no beat to M0, IDLE after RLAST.
REQ-039 S_ARREADY held 0 for 5 cycles in ADDR -> FSM stays ADDR, M_ARREADY stays 0, M0 ARVALID from other master ignored.
REQ-040 ARESETn low during DATA beat 2 of 4 -> next cycle IDLE, all valids/readies 0, p=0.
REQ-041 Alternating continuous requests from both masters for 8 bursts -> grants strictly alternate M0,M1,M0,...
